// File: rtl/map_hub_seq.sv
// Slot-selecting mapper hub with a runtime index-to-slot table.
// Each slot change passes through a reset window and a settle window before the new slot drives mao.
module map_hub_seq #(
    parameter int unsigned N_SLOT     = 8,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned SLOT_W     = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              map_idx,
    input  logic                    tbl_we,
    input  logic [7:0]              tbl_addr,
    input  logic [SLOT_W-1:0]       tbl_slot,
    input  logic [N_SLOT*OUT_W-1:0] slot_out,
    input  logic [OUT_W-1:0]        safe_out,
    output logic [OUT_W-1:0]        mao,
    output logic [N_SLOT-1:0]       slot_rst_n,
    output logic [SLOT_W-1:0]       cur_slot,
    output logic                    busy
);

    localparam int unsigned SETTLE_LEN = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
    localparam int unsigned CNT_MAX    = (RST_CYC > SETTLE_LEN) ? RST_CYC : SETTLE_LEN;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned SLOT_SPAN  = 1 << SLOT_W;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);

    typedef enum logic [1:0] {S_RST, S_SETTLE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   cur_q, cur_d;
    logic [SLOT_W-1:0]   lat_q, lat_d;
    logic [SLOT_W-1:0]   tgt_q, tgt_d;
    logic [OUT_W-1:0]    mao_q, mao_d;
    logic [N_SLOT-1:0]   srn_q, srn_d;
    logic [SLOT_W-1:0]   tbl_q [256];
    logic [SLOT_W-1:0]   raw_slot;
    logic [SLOT_SPAN-1:0] slot_ok;
    logic [OUT_W-1:0]    sel_out;

    function automatic logic [N_SLOT-1:0] onehot(input logic [SLOT_W-1:0] s);
        logic [N_SLOT-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < N_SLOT; k++) r[k] = (s == SLOT_W'(k));
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 256; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_slot;
        end
    end

    // Write-first bypass, then clamp table values that name a nonexistent slot to slot 0.
    always_comb begin
        slot_ok = '0;
        for (int unsigned k = 0; k < SLOT_SPAN; k++) slot_ok[k] = (k < N_SLOT);
        raw_slot = (tbl_we && (tbl_addr == map_idx)) ? tbl_slot : tbl_q[map_idx];
        tgt_d    = slot_ok[raw_slot] ? raw_slot : '0;
    end

    always_comb begin
        sel_out = '0;
        for (int unsigned k = 0; k < N_SLOT; k++) begin
            if (cur_q == SLOT_W'(k)) sel_out = slot_out[k*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        lat_d   = lat_q;
        case (state_q)
            S_RST: begin
                if (tgt_q != lat_q) begin
                    lat_d = tgt_q;
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (tgt_q != lat_q) begin
                    state_d = S_RST;
                    lat_d   = tgt_q;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    cur_d   = lat_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (tgt_q != cur_q) begin
                    state_d = S_RST;
                    lat_d   = tgt_q;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        // Slot resets follow the state being entered so they switch on the transition edge.
        case (state_d)
            S_SETTLE: srn_d = onehot(lat_d);
            S_RUN:    srn_d = onehot(cur_d);
            default:  srn_d = '0;
        endcase

        mao_d = (state_q == S_RUN) ? sel_out : safe_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            cur_q   <= '0;
            lat_q   <= '0;
            tgt_q   <= '0;
            mao_q   <= '0;
            srn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            lat_q   <= lat_d;
            tgt_q   <= tgt_d;
            mao_q   <= mao_d;
            srn_q   <= srn_d;
        end
    end

    assign mao        = mao_q;
    assign slot_rst_n = srn_q;
    assign cur_slot   = cur_q;
    assign busy       = (state_q != S_RUN);

endmodule

// File: tb/tb_map_hub_seq.sv
// Self-checking bench for map_hub_seq: a default 8-slot instance plus a 6-slot instance
// with short switch windows for the write-first and out-of-range table cases.
module tb_map_hub_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   map_idx = '0;
    logic         tbl_we = 1'b0;
    logic [7:0]   tbl_addr = '0;
    logic [2:0]   tbl_slot = '0;
    logic [511:0] slot_out = '0;
    logic [63:0]  safe_out = '0;
    logic [63:0]  mao;
    logic [7:0]   slot_rst_n;
    logic [2:0]   cur_slot;
    logic         busy;

    logic [7:0]   map_idx6 = 8'd6;
    logic         we6 = 1'b0;
    logic [7:0]   addr6 = '0;
    logic [2:0]   slot6 = '0;
    logic [47:0]  slot_out6 = '0;
    logic [7:0]   safe6 = 8'h5A;
    logic [7:0]   mao6;
    logic [5:0]   srn6;
    logic [2:0]   cur6;
    logic         busy6;

    logic [63:0]  sw [8];
    logic [63:0]  exp_q [$];
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    always #5 clk = ~clk;

    map_hub_seq #(.N_SLOT(8), .OUT_W(64), .RST_CYC(4), .SETTLE_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .map_idx(map_idx), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_slot(tbl_slot), .slot_out(slot_out), .safe_out(safe_out), .mao(mao),
        .slot_rst_n(slot_rst_n), .cur_slot(cur_slot), .busy(busy)
    );

    map_hub_seq #(.N_SLOT(6), .OUT_W(8), .RST_CYC(1), .SETTLE_CYC(0)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .map_idx(map_idx6), .tbl_we(we6), .tbl_addr(addr6),
        .tbl_slot(slot6), .slot_out(slot_out6), .safe_out(safe6), .mao(mao6),
        .slot_rst_n(srn6), .cur_slot(cur6), .busy(busy6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        for (int k = 0; k < 8; k++) begin
            sw[k] = {$urandom, $urandom};
            slot_out[k*64 +: 64] = sw[k];
        end
        safe_out  = {$urandom, $urandom};
        slot_out6 = {$urandom, $urandom[15:0]};
    endtask

    task automatic tbl_write(input logic [7:0] a, input logic [2:0] s);
        tbl_we = 1'b1; tbl_addr = a; tbl_slot = s;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e_srn;
        logic [63:0] e_mao;
        rst_n = 1'b0;
        new_data();
        tick(); tick();
        n_vec++; if (mao !== 64'h0) begin n_err++; $display("FAIL reset.mao got %h want 0", mao); end
        n_vec++; if (slot_rst_n !== 8'h00) begin n_err++; $display("FAIL reset.srn got %b want 0", slot_rst_n); end
        n_vec++; if (cur_slot !== 3'd0) begin n_err++; $display("FAIL reset.cur got %0d want 0", cur_slot); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset.busy got %b want 1", busy); end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            new_data();
            exp_q.push_back((i <= 6) ? safe_out : sw[0]);
            tick();
            e_mao = exp_q.pop_front();
            e_srn = (i <= 3) ? 8'h00 : 8'h01;
            n_vec++; if (busy !== (i <= 5)) begin n_err++; $display("FAIL post_reset.busy cyc %0d got %b want %b", i, busy, (i <= 5)); end
            n_vec++; if (slot_rst_n !== e_srn) begin n_err++; $display("FAIL post_reset.srn cyc %0d got %b want %b", i, slot_rst_n, e_srn); end
            n_vec++; if (cur_slot !== 3'd0) begin n_err++; $display("FAIL post_reset.cur cyc %0d got %0d want 0", i, cur_slot); end
            n_vec++; if (mao !== e_mao) begin n_err++; $display("FAIL post_reset.mao cyc %0d got %h want %h", i, mao, e_mao); end
        end
    endtask

    task automatic test_switch();
        logic [7:0] e_srn;
        logic [2:0] e_cur;
        logic [63:0] e_mao;
        tbl_write(8'd90, 3'd3);
        map_idx = 8'd90;
        for (int i = 1; i <= 10; i++) begin
            new_data();
            exp_q.push_back((i <= 2) ? sw[0] : (i <= 8) ? safe_out : sw[3]);
            tick();
            e_mao = exp_q.pop_front();
            e_srn = (i == 1) ? 8'h01 : (i <= 5) ? 8'h00 : 8'h08;
            e_cur = (i >= 8) ? 3'd3 : 3'd0;
            n_vec++; if (busy !== (i >= 2 && i <= 7)) begin n_err++; $display("FAIL switch.busy cyc %0d got %b", i, busy); end
            n_vec++; if (slot_rst_n !== e_srn) begin n_err++; $display("FAIL switch.srn cyc %0d got %b want %b", i, slot_rst_n, e_srn); end
            n_vec++; if (cur_slot !== e_cur) begin n_err++; $display("FAIL switch.cur cyc %0d got %0d want %0d", i, cur_slot, e_cur); end
            n_vec++; if (mao !== e_mao) begin n_err++; $display("FAIL switch.mao cyc %0d got %h want %h", i, mao, e_mao); end
        end
    endtask

    task automatic test_same_slot();
        logic [63:0] e_mao;
        tbl_write(8'd209, 3'd3);
        map_idx = 8'd209;
        for (int i = 1; i <= 8; i++) begin
            new_data();
            exp_q.push_back(sw[3]);
            tick();
            e_mao = exp_q.pop_front();
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_slot.busy cyc %0d got %b want 0", i, busy); end
            n_vec++; if (slot_rst_n !== 8'h08) begin n_err++; $display("FAIL same_slot.srn cyc %0d got %b want 00001000", i, slot_rst_n); end
            n_vec++; if (cur_slot !== 3'd3) begin n_err++; $display("FAIL same_slot.cur cyc %0d got %0d want 3", i, cur_slot); end
            n_vec++; if (mao !== e_mao) begin n_err++; $display("FAIL same_slot.mao cyc %0d got %h want %h", i, mao, e_mao); end
        end
    endtask

    task automatic test_retarget();
        logic [7:0] e_srn;
        logic [2:0] e_cur;
        logic [63:0] e_mao;
        map_idx = 8'd0;
        for (int i = 0; i < 12; i++) begin new_data(); tick(); end
        n_vec++; if (cur_slot !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL back_to_0 cur %0d busy %b want 0 0", cur_slot, busy); end
        tbl_write(8'd243, 3'd5);
        map_idx = 8'd90;
        for (int i = 1; i <= 13; i++) begin
            new_data();
            exp_q.push_back((i <= 2) ? sw[0] : (i <= 11) ? safe_out : sw[5]);
            tick();
            e_mao = exp_q.pop_front();
            e_srn = (i == 1) ? 8'h01 : (i <= 8) ? 8'h00 : 8'h20;
            e_cur = (i >= 11) ? 3'd5 : 3'd0;
            n_vec++; if (busy !== (i >= 2 && i <= 10)) begin n_err++; $display("FAIL retarget.busy cyc %0d got %b", i, busy); end
            n_vec++; if (slot_rst_n !== e_srn) begin n_err++; $display("FAIL retarget.srn cyc %0d got %b want %b", i, slot_rst_n, e_srn); end
            n_vec++; if (cur_slot !== e_cur) begin n_err++; $display("FAIL retarget.cur cyc %0d got %0d want %0d", i, cur_slot, e_cur); end
            n_vec++; if (mao !== e_mao) begin n_err++; $display("FAIL retarget.mao cyc %0d got %h want %h", i, mao, e_mao); end
            if (i == 3) map_idx = 8'd243;
        end
    endtask

    task automatic test_small_hub();
        logic [5:0] e_srn;
        logic [2:0] e_cur;
        we6 = 1'b1; addr6 = 8'd6; slot6 = 3'd4;
        tick();
        we6 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++; if (cur6 !== 3'd4 || busy6 !== 1'b0 || srn6 !== 6'b010000) begin n_err++; $display("FAIL small.slot4 cur %0d busy %b srn %b want 4 0 010000", cur6, busy6, srn6); end
        // Same-cycle write to the addressed entry must be seen by the next lookup.
        we6 = 1'b1; addr6 = 8'd6; slot6 = 3'd2;
        for (int i = 1; i <= 5; i++) begin
            tick();
            we6 = 1'b0;
            e_cur = (i >= 4) ? 3'd2 : 3'd4;
            e_srn = (i == 1) ? 6'b010000 : (i == 2) ? 6'b000000 : 6'b000100;
            n_vec++; if (cur6 !== e_cur) begin n_err++; $display("FAIL write_first.cur cyc %0d got %0d want %0d", i, cur6, e_cur); end
            n_vec++; if (srn6 !== e_srn) begin n_err++; $display("FAIL write_first.srn cyc %0d got %b want %b", i, srn6, e_srn); end
            n_vec++; if (busy6 !== (i == 2 || i == 3)) begin n_err++; $display("FAIL write_first.busy cyc %0d got %b", i, busy6); end
        end
        we6 = 1'b1; addr6 = 8'd5; slot6 = 3'd7;
        tick();
        we6 = 1'b0;
        map_idx6 = 8'd5;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e_cur = (i >= 4) ? 3'd0 : 3'd2;
            e_srn = (i == 1) ? 6'b000100 : (i == 2) ? 6'b000000 : 6'b000001;
            n_vec++; if (cur6 !== e_cur) begin n_err++; $display("FAIL out_of_range.cur cyc %0d got %0d want %0d", i, cur6, e_cur); end
            n_vec++; if (srn6 !== e_srn) begin n_err++; $display("FAIL out_of_range.srn cyc %0d got %b want %b", i, srn6, e_srn); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e_srn;
        logic [63:0] e_mao;
        map_idx = 8'd90;
        for (int i = 1; i <= 7; i++) begin new_data(); tick(); end
        n_vec++; if (busy !== 1'b1 || slot_rst_n !== 8'h08) begin n_err++; $display("FAIL mid.in_settle busy %b srn %b want 1 00001000", busy, slot_rst_n); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (mao !== 64'h0) begin n_err++; $display("FAIL mid.mao got %h want 0", mao); end
        n_vec++; if (slot_rst_n !== 8'h00) begin n_err++; $display("FAIL mid.srn got %b want 0", slot_rst_n); end
        n_vec++; if (cur_slot !== 3'd0 || busy !== 1'b1) begin n_err++; $display("FAIL mid.cur_busy got %0d %b want 0 1", cur_slot, busy); end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            new_data();
            exp_q.push_back((i <= 6) ? safe_out : sw[0]);
            tick();
            e_mao = exp_q.pop_front();
            e_srn = (i <= 3) ? 8'h00 : 8'h01;
            n_vec++; if (busy !== (i <= 5)) begin n_err++; $display("FAIL mid_rerun.busy cyc %0d got %b", i, busy); end
            n_vec++; if (slot_rst_n !== e_srn) begin n_err++; $display("FAIL mid_rerun.srn cyc %0d got %b want %b", i, slot_rst_n, e_srn); end
            n_vec++; if (cur_slot !== 3'd0) begin n_err++; $display("FAIL mid_rerun.cur cyc %0d got %0d want 0", i, cur_slot); end
            n_vec++; if (mao !== e_mao) begin n_err++; $display("FAIL mid_rerun.mao cyc %0d got %h want %h", i, mao, e_mao); end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_slot();
        test_retarget();
        test_small_hub();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
